payload_word_gather: RTL and testbench



---
 rtl/payload_word_gather.sv | 110 +++++++++++
 tb/tb_payload_word_gather.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_word_gather.sv
// Rebuilds one PAYLOAD_W-bit payload from little-endian WORD_W-bit words, with an accumulator and an output register.
// Define PAYLOAD_GATHER_ERR_CHECK_EN to enable s_last framing, m_err and the DISCARD state.
module payload_word_gather #(
    parameter int PAYLOAD_W = 100,
    parameter int WORD_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_W-1:0]    s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PAYLOAD_W-1:0] m_data,
    output logic                 m_err
);
    // Same word-count rule as the payload-to-words splitter: ceil(size / word).
    function automatic int get_word_count_for_size(input int size, input int word);
        return (size + word - 1) / word;
    endfunction

    localparam int NUM_WORDS = get_word_count_for_size(PAYLOAD_W, WORD_W);
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    // Moves a word to slot k; bits that land above PAYLOAD_W fall off the top.
    function automatic logic [PAYLOAD_W-1:0] place_word(input logic [WORD_W-1:0] w,
                                                        input logic [CNT_W-1:0]  k);
        return PAYLOAD_W'(w) << (int'(k) * WORD_W);
    endfunction

    logic [CNT_W-1:0]     r_cnt;
    logic [PAYLOAD_W-1:0] r_acc;
    logic                 r_m_valid;
    logic [PAYLOAD_W-1:0] r_m_data;
    logic [PAYLOAD_W-1:0] w_placed;
    logic                 w_cnt_last;
    logic                 w_closing;
    logic                 w_in_fire;
    logic                 w_out_fire;

    assign w_placed   = place_word(s_data, r_cnt);
    assign w_cnt_last = (r_cnt == CNT_W'(NUM_WORDS - 1));
    assign w_in_fire  = s_valid && s_ready;
    assign w_out_fire = r_m_valid && m_ready;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;

`ifdef PAYLOAD_GATHER_ERR_CHECK_EN
    typedef enum logic {ST_COLLECT, ST_DISCARD} state_t;
    state_t r_state;
    logic   r_m_err;
    logic   w_err_next;

    assign w_closing  = w_cnt_last || s_last;
    // Closing early (short) or running past the last slot (long) are both errors.
    assign w_err_next = w_cnt_last ? !s_last : 1'b1;
    assign s_ready    = !rst && ((r_state == ST_DISCARD) || !w_closing || !r_m_valid || m_ready);
    assign m_err      = r_m_err;
`else
    logic w_unused_last;

    assign w_unused_last = s_last;
    assign w_closing     = w_cnt_last;
    assign s_ready       = !rst && (!w_closing || !r_m_valid || m_ready);
    assign m_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
`ifdef PAYLOAD_GATHER_ERR_CHECK_EN
            r_m_err   <= 1'b0;
            r_state   <= ST_COLLECT;
`endif
        end else begin
            if (w_out_fire) begin
                r_m_valid <= 1'b0;
            end
            if (w_in_fire) begin
`ifdef PAYLOAD_GATHER_ERR_CHECK_EN
                if (r_state == ST_DISCARD) begin
                    if (s_last) begin
                        r_state <= ST_COLLECT;
                    end
                end else
`endif
                if (w_closing) begin
                    // Closing word bypasses the accumulator so the output loads this edge.
                    r_m_data  <= r_acc | w_placed;
                    r_m_valid <= 1'b1;
                    r_cnt     <= '0;
                    r_acc     <= '0;
`ifdef PAYLOAD_GATHER_ERR_CHECK_EN
                    r_m_err   <= w_err_next;
                    if (w_cnt_last && !s_last) begin
                        r_state <= ST_DISCARD;
                    end
`endif
                end else begin
                    r_acc <= r_acc | w_placed;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_payload_word_gather.sv
// Scoreboard bench for payload_word_gather at default widths; expectations follow PAYLOAD_GATHER_ERR_CHECK_EN.
module tb_payload_word_gather;
    typedef struct packed {
        logic [99:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [99:0] m_data;
    logic        m_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   pop_cyc[$];

    payload_word_gather #(.PAYLOAD_W(100), .WORD_W(32)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every presented payload is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_payload got=%h err=%b exp=none", m_data, m_err);
            end else begin
                if (m_data !== sb_q[0].data || m_err !== sb_q[0].err) begin
                    n_err++;
                    $display("FAIL payload got=%h err=%b exp=%h err=%b",
                             m_data, m_err, sb_q[0].data, sb_q[0].err);
                end
                if (m_ready) begin
                    void'(sb_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic expect_payload(input logic [99:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    // Presents one word and returns #1 after the edge that accepts it; s_valid stays high.
    task automatic send(input logic [31:0] d, input logic l, output int stalls);
        stalls  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        forever begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            stalls++;
            if (stalls > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout got=stalled exp=accept word=%h", d);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        int st;
        int tot;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_err", m_err, 0);
        @(posedge clk);
        #1;

        // Basic order and latency
        send(32'h11111111, 1'b0, st);
        send(32'h22222222, 1'b0, st);
        send(32'h33333333, 1'b0, st);
        expect_payload(100'hA_33333333_22222222_11111111, 1'b0);
        send(32'hFFFFFFFA, 1'b1, st);
        idle();
        check("lat_m_valid", m_valid, 1);
        check("lat_m_data", m_data, 100'hA_33333333_22222222_11111111);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back throughput
        tot = 0;
        send(32'h10000001, 1'b0, st); tot += st;
        send(32'h10000002, 1'b0, st); tot += st;
        send(32'h10000003, 1'b0, st); tot += st;
        expect_payload(100'h5_10000003_10000002_10000001, 1'b0);
        send(32'h10000005, 1'b1, st); tot += st;
        send(32'h20000001, 1'b0, st); tot += st;
        send(32'h20000002, 1'b0, st); tot += st;
        send(32'h20000003, 1'b0, st); tot += st;
        expect_payload(100'h6_20000003_20000002_20000001, 1'b0);
        send(32'h20000006, 1'b1, st); tot += st;
        idle();
        @(posedge clk);
        #1;
        check("b2b_stalls", tot, 0);
        if (pop_cyc.size() >= 2)
            check("b2b_spacing", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 4);
        else
            check("b2b_pops", pop_cyc.size(), 2);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure
        m_ready = 1'b1;
        send(32'hA0000001, 1'b0, st);
        send(32'hA0000002, 1'b0, st);
        send(32'hA0000003, 1'b0, st);
        expect_payload(100'h8_A0000003_A0000002_A0000001, 1'b0);
        send(32'hA0000008, 1'b1, st);
        m_ready = 1'b0;
        tot = 0;
        send(32'hB0000001, 1'b0, st); tot += st;
        send(32'hB0000002, 1'b0, st); tot += st;
        send(32'hB0000003, 1'b0, st); tot += st;
        check("bp_first3_stalls", tot, 0);
        expect_payload(100'h9_B0000003_B0000002_B0000001, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'hB0000009;
        s_last  = 1'b1;
        @(negedge clk);
        check("bp_s_ready_low", s_ready, 0);
        check("bp_hold_first", m_data, 100'h8_A0000003_A0000002_A0000001);
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        check("bp_s_ready_high", s_ready, 1);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        idle();
        check("bp_m_valid_kept", m_valid, 1);
        check("bp_second_loaded", m_data, 100'h9_B0000003_B0000002_B0000001);
        repeat (2) @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Short and long payloads
`ifdef PAYLOAD_GATHER_ERR_CHECK_EN
        send(32'hAAAAAAAA, 1'b0, st);
        expect_payload(100'h0_00000000_BBBBBBBB_AAAAAAAA, 1'b1);
        send(32'hBBBBBBBB, 1'b1, st);
        send(32'h01010101, 1'b0, st);
        send(32'h02020202, 1'b0, st);
        send(32'h03030303, 1'b0, st);
        expect_payload(100'hF_03030303_02020202_01010101, 1'b1);
        send(32'h0404040F, 1'b0, st);
        send(32'h05050505, 1'b0, st);
        send(32'h0606060E, 1'b1, st);
`else
        send(32'hAAAAAAAA, 1'b0, st);
        send(32'hBBBBBBBB, 1'b1, st);
        send(32'h01010101, 1'b0, st);
        expect_payload(100'h2_01010101_BBBBBBBB_AAAAAAAA, 1'b0);
        send(32'h02020202, 1'b0, st);
        send(32'h03030303, 1'b0, st);
        send(32'h0404040F, 1'b0, st);
        send(32'h05050505, 1'b0, st);
        expect_payload(100'hE_05050505_0404040F_03030303, 1'b0);
        send(32'h0606060E, 1'b1, st);
`endif
        send(32'hC0000001, 1'b0, st);
        send(32'hC0000002, 1'b0, st);
        send(32'hC0000003, 1'b0, st);
        expect_payload(100'h7_C0000003_C0000002_C0000001, 1'b0);
        send(32'hC0000007, 1'b1, st);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("framing_drained", sb_q.size(), 0);

        // Reset mid-payload
        send(32'hDEAD0001, 1'b0, st);
        send(32'hDEAD0002, 1'b0, st);
        s_data = 32'hDEAD0003;
        rst    = 1'b1;
        @(negedge clk);
        check("mid_rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        send(32'h50000001, 1'b0, st);
        send(32'h50000002, 1'b0, st);
        send(32'h50000003, 1'b0, st);
        expect_payload(100'hA_50000003_50000002_50000001, 1'b0);
        send(32'h5000000A, 1'b1, st);
        idle();
        check("post_rst_m_data", m_data, 100'hA_50000003_50000002_50000001);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
